// File: rtl/check_greater_pkg.sv
// -----------------------------------------------------------------------------
// check_greater_pkg
// Shared ALU compare definitions: default operand width, the compare-mode
// enum that the signed_mode pin maps onto, and the helper functions that
// compute the shape of the (gt, eq) reduction tree.
// -----------------------------------------------------------------------------
package check_greater_pkg;

  localparam int CMP_W = 8;

  typedef enum logic {
    CMP_UNSIGNED = 1'b0,
    CMP_SIGNED   = 1'b1
  } cmp_mode_e;

  // Number of (gt, eq) nodes at tree level lvl for a given operand width.
  // Level 0 holds one leaf per bit; each level halves the count, rounding
  // up so that an odd node is carried forward unchanged.
  function automatic int tree_cnt(input int width, input int lvl);
    return (width + (1 << lvl) - 1) >> lvl;
  endfunction

  // Offset of tree level lvl inside the flat node vector (sum of all the
  // levels below it). tree_off(width, last_level + 1) is the node total.
  function automatic int tree_off(input int width, input int lvl);
    int s;
    s = 0;
    for (int k = 0; k < lvl; k++) begin
      s += tree_cnt(width, k);
    end
    return s;
  endfunction

endpackage

// File: rtl/check_greater_merge.sv
// -----------------------------------------------------------------------------
// cmp_merge
// Two-input merge cell of the magnitude compare tree. Combines the result of
// a more-significant group (hi) with a less-significant group (lo):
//   gt = gt_hi | (eq_hi & gt_lo)
//   eq = eq_hi & eq_lo
// Ports:
//   i_gt_hi, i_eq_hi : result of the more-significant group
//   i_gt_lo, i_eq_lo : result of the less-significant group
//   o_gt, o_eq       : merged result
// -----------------------------------------------------------------------------
module cmp_merge (
  input  logic i_gt_hi,
  input  logic i_eq_hi,
  input  logic i_gt_lo,
  input  logic i_eq_lo,
  output logic o_gt,
  output logic o_eq
);

  assign o_gt = i_gt_hi | (i_eq_hi & i_gt_lo);
  assign o_eq = i_eq_hi & i_eq_lo;

endmodule

// File: rtl/check_greater.sv
// -----------------------------------------------------------------------------
// check_greater
// Magnitude comparator for the ALU datapath. g is the combinational a > b
// result feeding the flag logic; g_q/eq_q/lt_q are registered copies for the
// pipelined flag register, qualified by out_valid.
// Ports:
//   clk         : system clock, registered outputs update on rising edge
//   rst_n       : asynchronous active-low reset
//   a, b        : operands, WIDTH bits
//   signed_mode : 0 = unsigned compare, 1 = two's-complement compare
//   in_valid    : qualifies a/b/signed_mode for the registered path
//   g           : combinational a > b
//   g_q/eq_q/lt_q : registered a > b / a == b / a < b
//   out_valid   : in_valid delayed by one cycle
//
// Valid semantics: there is no ready/backpressure. Every cycle in which
// in_valid is high is one transaction; its result is captured on that rising
// edge and presented with out_valid high for exactly the following cycle.
// When in_valid is low the result registers keep their last value.
// -----------------------------------------------------------------------------
module check_greater
  import check_greater_pkg::*;
#(
  parameter int WIDTH = CMP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             in_valid,
  output logic             g,
  output logic             g_q,
  output logic             eq_q,
  output logic             lt_q,
  output logic             out_valid
);

  localparam int N_LVL  = $clog2(WIDTH);
  localparam int N_NODE = tree_off(WIDTH, N_LVL + 1);
  localparam int ROOT   = tree_off(WIDTH, N_LVL);

  cmp_mode_e        w_mode;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [N_NODE-1:0] w_gt_n;
  logic [N_NODE-1:0] w_eq_n;
  logic             w_gt;
  logic             w_eq;
  logic             w_lt;

  logic r_g;
  logic r_eq;
  logic r_lt;
  logic r_valid;

  assign w_mode = cmp_mode_e'(signed_mode);

  // Inverting both sign bits maps two's-complement order onto unsigned
  // order (-2^(W-1) becomes 0, 2^(W-1)-1 becomes all ones), so one
  // unsigned tree serves both modes.
  assign w_a = {a[WIDTH-1] ^ (w_mode == CMP_SIGNED), a[WIDTH-2:0]};
  assign w_b = {b[WIDTH-1] ^ (w_mode == CMP_SIGNED), b[WIDTH-2:0]};

  // Leaves: node i at level 0 is bit i, so higher node index = more
  // significant at every level.
  for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
    assign w_gt_n[i] = w_a[i] & ~w_b[i];
    assign w_eq_n[i] = ~(w_a[i] ^ w_b[i]);
  end

  // Reduction tree stored level by level in one flat vector. Pairs are
  // (2j+1 = hi, 2j = lo); a leftover top node is the most significant one
  // and moves up unchanged, which keeps the ordering intact.
  for (genvar l = 0; l < N_LVL; l++) begin : g_lvl
    localparam int CNT = tree_cnt(WIDTH, l);
    localparam int SRC = tree_off(WIDTH, l);
    localparam int DST = tree_off(WIDTH, l + 1);
    for (genvar j = 0; j < (CNT + 1) / 2; j++) begin : g_node
      if (2 * j + 1 < CNT) begin : g_merge
        cmp_merge u_merge (
          .i_gt_hi (w_gt_n[SRC + 2*j + 1]),
          .i_eq_hi (w_eq_n[SRC + 2*j + 1]),
          .i_gt_lo (w_gt_n[SRC + 2*j]),
          .i_eq_lo (w_eq_n[SRC + 2*j]),
          .o_gt    (w_gt_n[DST + j]),
          .o_eq    (w_eq_n[DST + j])
        );
      end else begin : g_pass
        assign w_gt_n[DST + j] = w_gt_n[SRC + 2*j];
        assign w_eq_n[DST + j] = w_eq_n[SRC + 2*j];
      end
    end
  end

  assign w_gt = w_gt_n[ROOT];
  assign w_eq = w_eq_n[ROOT];
  assign w_lt = ~w_gt & ~w_eq;

  assign g = w_gt;

  // eq resets to 1: an empty comparison reads as "equal".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g     <= 1'b0;
      r_eq    <= 1'b1;
      r_lt    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_g  <= w_gt;
        r_eq <= w_eq;
        r_lt <= w_lt;
      end
    end
  end

  assign g_q       = r_g;
  assign eq_q      = r_eq;
  assign lt_q      = r_lt;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_check_greater.sv
module tb_check_greater;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         signed_mode = 1'b0;
  logic         in_valid = 1'b0;
  logic         g;
  logic         g_q;
  logic         eq_q;
  logic         lt_q;
  logic         out_valid;

  int total = 0;
  int bad   = 0;

  // Expected {gt, eq, lt} per issued valid transaction.
  logic [2:0] exp_q[$];
  // Value the result registers must hold while out_valid is low.
  logic [2:0] m_hold;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vm;
    logic [2:0]   vr;
  } vec_t;

  // Hand-computed {gt, eq, lt}.
  vec_t vecs[12] = '{
    '{8'h2F, 8'h81, 1'b0, 3'b001},
    '{8'h80, 8'h00, 1'b0, 3'b100},
    '{8'h00, 8'h00, 1'b0, 3'b010},
    '{8'h2F, 8'h81, 1'b1, 3'b100},
    '{8'h80, 8'h00, 1'b1, 3'b001},
    '{8'h00, 8'h00, 1'b1, 3'b010},
    '{8'h7F, 8'h80, 1'b1, 3'b100},
    '{8'h7F, 8'h80, 1'b0, 3'b001},
    '{8'hFF, 8'hFE, 1'b0, 3'b100},
    '{8'hFF, 8'h00, 1'b0, 3'b100},
    '{8'hFF, 8'hFE, 1'b1, 3'b100},
    '{8'hA5, 8'hA5, 1'b1, 3'b010}
  };

  check_greater #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .in_valid    (in_valid),
    .g           (g),
    .g_q         (g_q),
    .eq_q        (eq_q),
    .lt_q        (lt_q),
    .out_valid   (out_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mm);
    logic gt, eq;
    if (mm) gt = $signed(ma) > $signed(mb);
    else    gt = ma > mb;
    eq = (ma == mb);
    return {gt, eq, ~gt & ~eq};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db, input logic dm,
                       input logic dv, input logic [2:0] dr);
    @(negedge clk);
    a = da;
    b = db;
    signed_mode = dm;
    in_valid = dv;
    if (dv) exp_q.push_back(dr);
    #1;
    chk("comb_g", g, dr[2]);
  endtask

  task automatic chk_reset_vals();
    chk("rst_g_q", g_q, 0);
    chk("rst_eq_q", eq_q, 1);
    chk("rst_lt_q", lt_q, 0);
    chk("rst_out_valid", out_valid, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    m_hold = 3'b010;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_hold = 3'b010;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_valid_unexpected", out_valid, 0);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          chk("reg_result", {g_q, eq_q, lt_q}, e);
          chk("reg_onehot", $countones({g_q, eq_q, lt_q}), 1);
          m_hold = e;
        end
      end else begin
        chk("reg_hold", {g_q, eq_q, lt_q}, m_hold);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] row_got;
    logic [255:0] row_exp;
    logic [2:0]   r;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, back-to-back valid.
    foreach (vecs[i]) begin
      drive(vecs[i].va, vecs[i].vb, vecs[i].vm, 1'b1, vecs[i].vr);
    end

    // Registered capture then hold.
    drive(8'h10, 8'h10, 1'b0, 1'b1, 3'b010);
    drive(8'h20, 8'h10, 1'b0, 1'b0, 3'b100);
    chk("cap_g_q", g_q, 0);
    chk("cap_eq_q", eq_q, 1);
    chk("cap_lt_q", lt_q, 0);
    chk("cap_out_valid", out_valid, 1);
    @(posedge clk);
    #2;
    chk("hold_g_q", g_q, 0);
    chk("hold_eq_q", eq_q, 1);
    chk("hold_lt_q", lt_q, 0);
    chk("hold_out_valid", out_valid, 0);

    // Asynchronous reset between edges after a g_q = 1 result.
    drive(8'h7F, 8'h80, 1'b1, 1'b1, 3'b100);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 3'b010);
    chk("pre_rst_g_q", g_q, 1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    // First result after reset release.
    drive(8'h01, 8'h02, 1'b0, 1'b1, 3'b001);

    // Mixed-valid stimulus against the behavioural model.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ra, rb;
      logic rm, rv;
      ra = W'($urandom_range(0, 255));
      rb = (i % 5 == 0) ? ra : W'($urandom_range(0, 255));
      rm = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      drive(ra, rb, rm, rv, model(ra, rb, rm));
    end

    // Exhaustive combinational sweep, one comparison per (mode, a) row.
    @(negedge clk);
    in_valid = 1'b0;
    for (int m = 0; m < 2; m++) begin
      for (int ai = 0; ai < 256; ai++) begin
        row_got = '0;
        row_exp = '0;
        for (int bi = 0; bi < 256; bi++) begin
          a = W'(ai);
          b = W'(bi);
          signed_mode = 1'(m);
          #1;
          r = model(W'(ai), W'(bi), 1'(m));
          row_got[bi] = g;
          row_exp[bi] = r[2];
        end
        chk((m == 0) ? "sweep_unsigned_row" : "sweep_signed_row", row_got, row_exp);
      end
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
